uart_rx_oversampled: RTL and testbench
======================================

UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of flops in rx_in synchronizer (min 2).
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rstN  input  1  asynchronous, active-low reset.
REQ-004 s_tick  input  1  oversample strobe, one clk wide, OVERSAMPLE_RATE (16) ticks per bit.
REQ-005 rx_in  input  1  asynchronous serial line, idle high, 8N1 frame, LSB first.
REQ-006 rx_data  output  8  last correctly framed byte.
REQ-007 rx_done  output  1  one-clk pulse: rx_data updated.
REQ-008 busy  output  1  frame in progress.
REQ-009 err  output  1  one-clk pulse: framing error (stop bit sampled low).
REQ-010 parity_err  output  1  one-clk pulse: parity mismatch; constant 0 when RX_PARITY_EN undefined.

Function
REQ-011 rx_in SHALL pass through SYNC_STAGES flops (reset value 1) before use; all FSM sampling uses synchronized rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY (only with RX_PARITY_EN), STOP.
REQ-013 Tick counter s (4 bits) and bit counter n (3 bits) SHALL advance only on cycles with s_tick=1; without s_tick all state holds.
REQ-014 IDLE: rx_s==0 -> START, s=0; busy=0 in IDLE only.
REQ-015 START: on tick with s==7 (mid-bit): rx_s==0 -> DATA, s=0, n=0; rx_s==1 -> IDLE, no err (glitch reject); else s++.
REQ-016 DATA: on tick with s==15: shift rx_s into MSB of shift register, s=0; n==7 -> PARITY (macro on) or STOP, else n++; else s++.
REQ-017 STOP: on tick with s==15: rx_s==1 -> rx_data<=shift register, rx_done pulse; rx_s==0 -> err pulse, rx_data unchanged; both -> IDLE.
REQ-018 rx_done, err, parity_err SHALL be registered, asserted exactly one clk, cycle after the deciding tick; never rx_done with err or parity_err.
REQ-019 Return to IDLE at stop-bit midpoint SHALL allow a back-to-back start bit to be detected with no lost frame.
REQ-020 rx_in held low continuously (break) SHALL yield err per frame, then wait in IDLE-to-START cycles; no lockup.

Reset
REQ-021 rstN low SHALL immediately force: state IDLE, s=0, n=0, shift register 0, rx_data 0x00, rx_done 0, err 0, parity_err 0, busy 0, synchronizer flops 1.
REQ-022 Reset mid-frame SHALL discard the partial frame; no pulse on release.

Configuration
REQ-023 Macro RX_PARITY_EN defined: PARITY state after DATA; on tick s==15 compare rx_s to even parity of received byte, s=0 -> STOP; mismatch latched and reported as parity_err pulse at stop decision instead of rx_done, rx_data unchanged; framing error takes priority (err only).
REQ-024 RX_PARITY_EN undefined: no PARITY state, DATA -> STOP directly, parity_err tied 0.

Structure
REQ-025 OVERSAMPLE_RATE (16), START_MID (7) and the rx state enum SHALL live in definitions_pkg, shared with the transmitter.
REQ-026 Synchronizer SHALL be sub-module uart_rx_sync (parameter SYNC_STAGES, async active-low reset to 1).

Verification
REQ-027 Frame 0xA5, 16 ticks/bit, stop=1 -> rx_data=0xA5, one rx_done pulse, err=0, busy high start-detect through stop.
REQ-028 Low glitch of 4 ticks on idle line -> return to IDLE, no rx_done/err, rx_data unchanged.
REQ-029 Frame 0x3C with stop bit 0 -> one err pulse, rx_data keeps prior value, next frame 0x55 received correctly.
REQ-030 Back-to-back 0x00 then 0xFF, no idle gap -> two rx_done pulses, data 0x00 then 0xFF.
REQ-031 rstN asserted during DATA bit 4 of 0x81 -> all outputs reset immediately; subsequent 0x81 received correctly.
REQ-032 RX_PARITY_EN: 0x07 with parity 1 -> rx_done, rx_data=0x07; with parity 0 -> parity_err pulse, no rx_done.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared UART definitions (oversample rate, mid-bit point, rx state enum) for receiver and transmitter.
// RX_PARITY_EN adds the PARITY state to the rx state enum.
// No logic, no latency, no backpressure.
package definitions_pkg;

    localparam int         OVERSAMPLE_RATE = 16;
    localparam logic [3:0] START_MID       = 4'd7;
    localparam logic [3:0] TICK_LAST       = 4'(OVERSAMPLE_RATE - 1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef RX_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; flops reset to idle-high.
// Latency: SYNC_STAGES clk cycles.
// No backpressure: samples every clk.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstN,
    input  logic rx_in,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign rx_s = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver on a 16x oversample tick; optional even parity bit with RX_PARITY_EN.
// Latency: rx_done/err/parity_err pulse one clk after the stop-bit mid-point tick.
// No backpressure: each frame result is a single-cycle pulse and must be consumed when presented.
module uart_rx_oversampled
    import definitions_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic       s_tick,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       busy,
    output logic       err,
    output logic       parity_err
);

    logic       w_rx_s;
    rx_state_t  r_state;
    logic [3:0] r_s;
    logic [2:0] r_n;
    logic [7:0] r_shift;
    logic [7:0] r_rx_data;
    logic       r_rx_done;
    logic       r_err;
    logic       r_busy;
`ifdef RX_PARITY_EN
    logic       r_par_bad;
    logic       r_parity_err;
`endif

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rstN  (rstN),
        .rx_in (rx_in),
        .rx_s  (w_rx_s)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= RX_IDLE;
            r_s       <= '0;
            r_n       <= '0;
            r_shift   <= '0;
            r_rx_data <= '0;
            r_rx_done <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
`ifdef RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_done <= 1'b0;
            r_err     <= 1'b0;
`ifdef RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (s_tick) begin
                case (r_state)
                    RX_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= RX_START;
                            r_s     <= '0;
                            r_busy  <= 1'b1;
`ifdef RX_PARITY_EN
                            r_par_bad <= 1'b0;
`endif
                        end
                    end
                    RX_START: begin
                        if (r_s == START_MID) begin
                            r_s <= '0;
                            if (!w_rx_s) begin
                                r_state <= RX_DATA;
                                r_n     <= '0;
                            end else begin
                                // line went high again before mid-bit: treat as glitch
                                r_state <= RX_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                    RX_DATA: begin
                        if (r_s == TICK_LAST) begin
                            r_s     <= '0;
                            r_shift <= {w_rx_s, r_shift[7:1]};
                            if (r_n == 3'd7) begin
`ifdef RX_PARITY_EN
                                r_state <= RX_PARITY;
`else
                                r_state <= RX_STOP;
`endif
                            end else begin
                                r_n <= r_n + 3'd1;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
`ifdef RX_PARITY_EN
                    RX_PARITY: begin
                        if (r_s == TICK_LAST) begin
                            r_s       <= '0;
                            r_par_bad <= (w_rx_s != even_parity(r_shift));
                            r_state   <= RX_STOP;
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
`endif
                    RX_STOP: begin
                        if (r_s == TICK_LAST) begin
                            // decide at stop mid-bit so a back-to-back start edge is not missed
                            r_s     <= '0;
                            r_state <= RX_IDLE;
                            r_busy  <= 1'b0;
                            if (!w_rx_s) begin
                                r_err <= 1'b1;
`ifdef RX_PARITY_EN
                            end else if (r_par_bad) begin
                                r_parity_err <= 1'b1;
`endif
                            end else begin
                                r_rx_data <= r_shift;
                                r_rx_done <= 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= RX_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data = r_rx_data;
    assign rx_done = r_rx_done;
    assign busy    = r_busy;
    assign err     = r_err;
`ifdef RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: frames are serialized from a bit-level model,
// the expected result is queued per frame and a monitor pops it on every output pulse.
module tb_uart_rx_oversampled;

    logic       clk = 1'b0;
    logic       rstN;
    logic       s_tick;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       busy;
    logic       err;
    logic       parity_err;

    localparam int K_DONE = 0;
    localparam int K_ERR  = 1;
    localparam int K_PERR = 2;
`ifdef RX_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    // ticks from start detection to the next possible start detection on a stuck-low line
    localparam int FRAME_TICKS = 8 + 16 * NBITS + 1;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] last_good = 8'h00;
    int         total = 0;
    int         bad = 0;

    uart_rx_oversampled #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .s_tick     (s_tick),
        .rx_in      (rx_in),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .busy       (busy),
        .err        (err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        tick(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        exp_t e;
        logic pbit;
        pbit = 1'b0;
        for (int i = 0; i < 8; i++) pbit = pbit ^ d[i];
        if (!stop_bit) begin
            e.kind = K_ERR;
            e.data = last_good;
`ifdef RX_PARITY_EN
        end else if (par_flip) begin
            e.kind = K_PERR;
            e.data = last_good;
`endif
        end else begin
            e.kind = K_DONE;
            e.data = d;
            last_good = d;
        end
        q.push_back(e);
        rx_in = 1'b0;
        tick(16);
        chk("busy_in_frame", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            tick(16);
        end
`ifdef RX_PARITY_EN
        rx_in = pbit ^ par_flip;
        tick(16);
`endif
        rx_in = stop_bit;
        tick(16);
        if (stop_bit) chk("busy_after_stop", {31'b0, busy}, 32'd0);
    endtask

    // monitor: every output pulse must match the oldest outstanding expectation
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (rx_done || err || parity_err) begin
                chk("pulse_exclusive", int'(rx_done) + int'(err) + int'(parity_err), 32'd1);
                k = rx_done ? K_DONE : (err ? K_ERR : K_PERR);
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse actual_kind=%0d rx_data=0x%02h required=none", k, rx_data);
                end else begin
                    e = q.pop_front();
                    chk("pulse_kind", k, e.kind);
                    chk("rx_data", {24'b0, rx_data}, {24'b0, e.data});
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       sb;
        logic       pf;
        rx_in  = 1'b1;
        s_tick = 1'b0;
        rstN   = 1'b0;
        #1;
        chk("rst_rx_data", {24'b0, rx_data}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rx_done", {31'b0, rx_done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_parity_err", {31'b0, parity_err}, 32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        idle(20);

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(10);

        // short low glitch on an idle line
        rx_in = 1'b0;
        tick(4);
        idle(30);
        chk("glitch_busy", {31'b0, busy}, 32'd0);
        chk("glitch_rx_data", {24'b0, rx_data}, {24'b0, last_good});

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(20);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(5);

        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(10);

        // reset while bit 4 of 0x81 is on the line
        d = 8'h81;
        rx_in = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            tick(16);
        end
        rx_in = d[4];
        tick(5);
        rstN = 1'b0;
        #1;
        chk("midrst_rx_data", {24'b0, rx_data}, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_pulses", {29'b0, rx_done, err, parity_err}, 32'd0);
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        rstN  = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(10);

        // break: stuck-low line gives one framing error per frame period
        for (int i = 0; i < 2; i++) q.push_back('{kind: K_ERR, data: last_good});
        rx_in = 1'b0;
        tick(2 * FRAME_TICKS + 4);
        idle(40);
        chk("break_busy", {31'b0, busy}, 32'd0);

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(5);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
`endif

        for (int f = 0; f < 12; f++) begin
            d  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pf = ($urandom_range(0, 3) == 0);
            send_frame(d, sb, pf);
            if (!sb) idle(12 + $urandom_range(0, 8));
            else idle($urandom_range(0, 6));
        end

        idle(30);
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
